fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin write arbiter that lets N_REQ producers share the single write
//   port of one FIFO buffer. Each producer holds a request with its data word.
//   The arbiter grants one owner at a time for up to BURST words and drives the
//   FIFO's wr/w_data. It never writes while the FIFO reports full.
// PARAMETERS
//   DATA_WIDTH  8  width of each data word; must match the FIFO
//   N_REQ       4  number of requesters, >= 2
//   BURST       4  max words written per grant before forced re-arbitration, >= 1
// PORTS
//   clk          in   1                 clock, rising edge
//   reset        in   1                 asynchronous, active-low reset
//   req          in   N_REQ             req[i]=1: requester i holds a valid word
//   req_data     in   N_REQ*DATA_WIDTH  word i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full    in   1                 full flag from the FIFO
//   ack          out  N_REQ             one-hot; ack[i]=1 means word i is written this cycle
//   grant        out  N_REQ             one-hot registered current owner; 0 when idle
//   fifo_wr      out  1                 write strobe to the FIFO
//   fifo_w_data  out  DATA_WIDTH        write data to the FIFO
//   busy         out  1                 1 while in OWN
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE, grant=0, count=0, last=N_REQ-1
//     (req[0] is first in priority). fifo_wr, ack and busy are 0 and fifo_w_data is 0.
//   - State IDLE: if any req is set, register grant = first set req scanning
//     last+1, last+2, ... with wrap-around. Go to OWN and set count=0.
//     If no req is set, stay in IDLE.
//   - State OWN (owner o = the grant index):
//     - write = req[o] & ~fifo_full. This is combinational from the registered grant.
//     - fifo_wr = write, ack[o] = write, fifo_w_data = word o (0 when not writing).
//     - On each write, count increments. Counter width is $clog2(BURST+1).
//   - Release condition in OWN: (req[o]==0) or (write and count==BURST-1).
//     - On release: last=o and count=0.
//     - Next owner is chosen by the same scan from o+1 using the current req.
//       If the owner's burst ended and it still requests, it can be re-chosen,
//       but only after all others in the scan order.
//     - A next owner is granted on the next edge with no idle bubble.
//       If no req is set, go to IDLE.
//   - fifo_full in OWN: no write and no ack. count and grant hold.
//     Full never causes a release; req[o] dropping still does.
//   - Latency: req set in IDLE at edge t gives grant at t+1 and the first write
//     in cycle t+1 (if not full). Throughput is 1 word/cycle, including across grant handoffs.
//   - Requester contract: req_data[i] is stable while req[i]=1 and ack[i]=0.
//     A requester may drop req at any time; an un-acked word is not written.
//   - Reset mid-burst aborts the burst. Words already acked stay in the FIFO.
//   - The arbiter does not exploit a simultaneous FIFO read to write when full.
// TESTING
//   1. N_REQ=4, BURST=4; only req[1] set, 6 words, FIFO empty ->
//      grant=0010 from cycle 1, ack[1] on cycles 1-4, re-grant req1 at cycle 5
//      with no bubble, 6 fifo_wr total, data in order.
//   2. req=1111 held with distinct words -> grant sequence 0,1,2,3,0;
//      exactly 4 writes per owner; fifo_wr high every cycle after the first grant.
//   3. Owner 0 mid-burst (count=2), fifo_full=1 for 3 cycles ->
//      fifo_wr=0, ack=0, grant=0001 held; after full drops, exactly 2 more writes.
//   4. Owner 2 drops req after 2 writes while req[3]=1 ->
//      grant=1000 on the next edge; words 3 written next.
//   5. reset=0 asynchronously mid-burst -> grant, ack and fifo_wr are 0 before the next edge.
//      After release with req=0101 -> grant=0001 first, then 0100.
//   6. Scoreboard: FIFO contents equal the union of acked words in ack order.
//      No write ever occurs while fifo_full=1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// One owner at a time, up to BURST words per grant, no write while full.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int BURST      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                        fifo_full,
  output logic [N_REQ-1:0]            ack,
  output logic [N_REQ-1:0]            grant,
  output logic                        fifo_wr,
  output logic [DATA_WIDTH-1:0]       fifo_w_data,
  output logic                        busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0]    C_LAST = CW'(BURST - 1);
  localparam logic [IW-1:0]    I_LAST = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE    = N_REQ'(1);

  typedef enum logic {
    S_IDLE,
    S_OWN
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [N_REQ-1:0]      r_grant;
  logic [N_REQ-1:0]      w_grant_nxt;
  logic [IW-1:0]         r_owner;
  logic [IW-1:0]         w_owner_nxt;
  logic [IW-1:0]         r_last;
  logic [IW-1:0]         w_last_nxt;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic [IW-1:0]         w_base;
  logic [IW-1:0]         w_idx;
  logic [IW-1:0]         w_pick;
  logic [N_REQ-1:0]      w_pick_oh;
  logic                  w_own_req;
  logic                  w_write;
  logic                  w_release;
  logic                  w_any;
  logic [DATA_WIDTH-1:0] w_word;

  // The scan starts after the current owner in OWN so that a
  // burst-expired owner is reconsidered only after everyone else.
  assign w_base    = (r_state == S_OWN) ? r_owner : r_last;
  assign w_any     = |req;
  assign w_own_req = |(req & r_grant);
  assign w_write   = (r_state == S_OWN) & w_own_req & ~fifo_full;
  assign w_release = (r_state == S_OWN) &
                     (~w_own_req | (w_write & (r_count == C_LAST)));
  assign w_pick_oh = ONE << w_pick;

  // Round-robin pick: first set req after w_base, wrapping, w_base last
  always_comb begin
    w_pick = w_base;
    w_idx  = w_base;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = IW'((int'(w_base) + k) % N_REQ);
      if (req[w_idx]) w_pick = w_idx;
    end
  end

  // Select the owner's data word from the packed request bus
  always_comb begin
    w_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) w_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_wr     = w_write;
  assign ack         = w_write ? r_grant : '0;
  assign fifo_w_data = w_write ? w_word : '0;
  assign grant       = r_grant;
  assign busy        = (r_state == S_OWN);

  // Next-state: grant from IDLE, count/release/hand off in OWN
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_count_nxt = r_count;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_OWN;
          w_grant_nxt = w_pick_oh;
          w_owner_nxt = w_pick;
          w_count_nxt = '0;
        end
      end
      S_OWN: begin
        if (w_write) w_count_nxt = r_count + CW'(1);
        if (w_release) begin
          w_last_nxt  = r_owner;
          w_count_nxt = '0;
          if (w_any) begin
            w_grant_nxt = w_pick_oh;
            w_owner_nxt = w_pick;
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State registers; async reset aborts any burst in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= I_LAST;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_count <= w_count_nxt;
    end
  end

endmodule
